piso_reg: RTL and testbench
===========================

// Module: piso_reg
// PURPOSE
//  Parallel-in serial-out shift register. Transmit-side counterpart of the 4-bit SIPO capture register.
//  Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled
//  clock on a serial line, with frame markers. A held or pipelined SIPO at the far end reassembles the word.
// PARAMETERS
//  WIDTH      4  word length in bits; legal range >= 2
//  MSB_FIRST  1  1: transmit bit WIDTH-1 first; 0: transmit bit 0 first
// PORTS
//  clk          in   1          single clock; all state updates on posedge clk
//  rst          in   1          synchronous, active-high reset
//  pi           in   WIDTH      parallel word to serialize; sampled only on an accepted load
//  load_valid   in   1          word on pi is valid
//  load_ready   out  1          block can accept a word this cycle
//  shift_en     in   1          advance enable; 0 stalls all shifting state
//  so           out  1          serial data out
//  so_valid     out  1          so carries a frame bit this cycle
//  frame_start  out  1          so carries the first bit of a frame
//  frame_done   out  1          so carries the last bit of a frame
// BEHAVIOUR
//  State: 2-state FSM, IDLE/SHIFT. Data: shift register sreg[WIDTH-1:0] and bit counter cnt[$clog2(WIDTH)-1:0].
//  Reset (sync, rst=1 at posedge): state=IDLE, sreg=0, cnt=0.
//   All outputs are 0 while rst=1. load_ready is gated by !rst.
//   Reset mid-frame aborts the frame: no frame_done, remaining bits discarded.
//  Outputs, decoded from registers only (no combinational path from inputs except load_ready's rst gate):
//   so          = MSB_FIRST ? sreg[WIDTH-1] : sreg[0]; 0 in IDLE
//   so_valid    = (state==SHIFT)
//   frame_start = (state==SHIFT) && (cnt==WIDTH-1)
//   frame_done  = (state==SHIFT) && (cnt==0)
//   load_ready  = !rst && ((state==IDLE) || (state==SHIFT && cnt==0 && shift_en))
//  Handshake: a load is accepted when load_valid && load_ready at a posedge.
//   Accept action: sreg<=pi, cnt<=WIDTH-1, state<=SHIFT.
//   Latency: word accepted at edge N; first bit on so in cycle N+1; last bit in cycle N+WIDTH when shift_en stays 1.
//  IDLE, no accept: hold, sreg=0.
//  SHIFT, shift_en=0: sreg, cnt and state hold. so and markers stay unchanged (stall).
//  SHIFT, shift_en=1, cnt!=0: shift toward the output end, zero-fill the vacated bit, cnt<=cnt-1.
//  SHIFT, shift_en=1, cnt==0:
//   - if a load is accepted: reload (back-to-back); so_valid stays 1 with no gap
//   - else: state<=IDLE, sreg<=0
//  load_valid while load_ready=0 is ignored. pi is not sampled and the request is not queued.
//   The source must hold load_valid until it sees load_ready.
//  A word of all zeros is a legal frame: so=0 for WIDTH cycles with so_valid=1.
// STRUCTURE
//  Shared package sr_pkg holds the FSM state localparams (SR_IDLE=1'b0, SR_SHIFT=1'b1).
//   The SIPO side uses the same package for its receive-side counter.
//  One natural sub-module: sr_bit_counter.
//   Parameters: WIDTH. Ports: load, dec, cnt, zero. It implements the down-counter and cnt==0 flag.
//  Shift register, FSM and output decode stay in piso_reg.
// TESTING  (WIDTH=4, MSB_FIRST=1 unless stated)
//  1 basic: pi=4'b1011, load pulse, shift_en=1
//    -> so=1,0,1,1 in cycles N+1..N+4; frame_start only at N+1; frame_done only at N+4; then so_valid=0, so=0
//  2 back-to-back: 1011 accepted, 0110 held valid and accepted at the last bit
//    -> 8 contiguous bits 1,0,1,1,0,1,1,0; so_valid never drops; two frame_start and two frame_done pulses
//  3 stall: 1011 with shift_en=0 for 2 cycles after bit 2 -> so=0 held 3 cycles total; sequence otherwise 1,0,1,1
//  4 LSB-first: MSB_FIRST=0, pi=4'b1011 -> so=1,1,0,1
//  5 busy load: load_valid with pi=4'b0000 during bit 1 of a 1011 frame -> ignored; frame output unchanged
//  6 reset mid-frame: rst=1 after bit 2
//    -> next cycle so_valid=0, so=0, no frame_done; cycle after rst drops load_ready=1 and a new load works

Source files
------------

// File: rtl/sr_pkg.sv
// ============================================================================
//  Module : sr_pkg
//  Shared FSM encodings for the serial shift-register family (PISO and SIPO).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package sr_pkg;

    localparam logic [0:0] SR_IDLE  = 1'b0;
    localparam logic [0:0] SR_SHIFT = 1'b1;

    // Counter width for a WIDTH-bit frame; never narrower than one bit.
    function automatic int sr_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_bit_counter.sv
// ============================================================================
//  Module : sr_bit_counter
//  Frame bit down-counter: loads WIDTH-1, steps down on dec, flags zero.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module sr_bit_counter
    import sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           dec,
    output logic [sr_cnt_width(WIDTH)-1:0] cnt,
    output logic                           zero
);

    localparam int                 CW     = sr_cnt_width(WIDTH);
    localparam logic [CW-1:0]      c_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_LAST;
        end else if (dec) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/piso_reg.sv
// ============================================================================
//  Module : piso_reg
//  Parallel-in serial-out shift register with valid/ready load and frame marks.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module piso_reg
    import sr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int            CW     = sr_cnt_width(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    w_cnt;
    logic             w_zero;
    logic             w_in_shift;
    logic             w_accept;
    logic             w_dec;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign w_in_shift = (r_state == SR_SHIFT);
    // Ready on the last bit only when that bit actually leaves this cycle.
    assign load_ready = !rst && (!w_in_shift || (w_zero && shift_en));
    assign w_accept   = load_valid && load_ready;
    assign w_dec      = w_in_shift && shift_en && !w_zero;

    sr_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .dec  (w_dec),
        .cnt  (w_cnt),
        .zero (w_zero)
    );

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_out_bit = r_sreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SR_IDLE;
            r_sreg  <= '0;
        end else if (w_accept) begin
            r_state <= SR_SHIFT;
            r_sreg  <= pi;
        end else if (w_in_shift && shift_en) begin
            if (w_zero) begin
                r_state <= SR_IDLE;
                r_sreg  <= '0;
            end else begin
                r_sreg  <= w_shifted;
            end
        end
    end

    assign so          = w_in_shift && w_out_bit;
    assign so_valid    = w_in_shift;
    assign frame_start = w_in_shift && (w_cnt == c_LAST);
    assign frame_done  = w_in_shift && w_zero;

endmodule

`default_nettype wire

// File: tb/tb_piso_reg.sv
// ============================================================================
//  Module : tb_piso_reg
//  Self-checking bench for piso_reg (WIDTH=4, MSB- and LSB-first instances).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_piso_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pi = '0;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic       load_ready, so, so_valid, frame_start, frame_done;

    logic [3:0] l_pi = '0;
    logic       l_load_valid = 1'b0;
    logic       l_shift_en = 1'b0;
    logic       l_load_ready, l_so, l_so_valid, l_frame_start, l_frame_done;

    int vectors = 0;
    int fails   = 0;

    // Expected serial stream, one entry per bit: {so, frame_start, frame_done}
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    piso_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid),
        .load_ready(load_ready), .shift_en(shift_en), .so(so),
        .so_valid(so_valid), .frame_start(frame_start), .frame_done(frame_done)
    );

    piso_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .pi(l_pi), .load_valid(l_load_valid),
        .load_ready(l_load_ready), .shift_en(l_shift_en), .so(l_so),
        .so_valid(l_so_valid), .frame_start(l_frame_start), .frame_done(l_frame_done)
    );

    task automatic push_word(input logic [3:0] w, input bit msb);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({msb ? w[3-i] : w[i], 1'(i == 0), 1'(i == 3)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b1; pi = 4'hF; shift_en = 1'b1;
        l_load_valid = 1'b1; l_pi = 4'hF; l_shift_en = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({so, so_valid, frame_start, frame_done, load_ready} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs got %b want 00000", {so, so_valid, frame_start, frame_done, load_ready});
        end
        vectors++;
        if ({l_so, l_so_valid, l_frame_start, l_frame_done, l_load_ready} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs_lsb got %b want 00000", {l_so, l_so_valid, l_frame_start, l_frame_done, l_load_ready});
        end
        rst = 1'b0; load_valid = 1'b0; l_load_valid = 1'b0;
        #1;
        vectors++;
        if (load_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready got %b want 1", load_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_basic();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            vectors++;
            if (so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL basic c%0d so_valid got %b want %b", c, so_valid, exp_q.size() != 0);
            end else if (so_valid) begin
                vectors++;
                if ({so, frame_start, frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL basic c%0d so/start/done got %b want %b", c, {so, frame_start, frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({so, frame_start, frame_done} !== 3'b000) begin
                    fails++; $display("FAIL basic c%0d idle got %b want 000", c, {so, frame_start, frame_done});
                end
            end
            shift_en   = 1'b1;
            load_valid = (c == 0) || (c == 6);
            pi         = (c == 0) ? 4'b1011 : 4'b0000;
            #1;
            if (load_valid) begin
                vectors++;
                if (load_ready !== 1'b1) begin
                    fails++; $display("FAIL basic c%0d load_ready got %b want 1", c, load_ready);
                end
            end
            if (so_valid && shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
            if (load_valid) push_word(pi, 1'b1);
        end
        load_valid = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL basic leftover bits got %0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int n_start = 0;
        int n_done  = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            vectors++;
            if (so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL b2b c%0d so_valid got %b want %b", c, so_valid, exp_q.size() != 0);
            end else if (so_valid) begin
                vectors++;
                if ({so, frame_start, frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL b2b c%0d so/start/done got %b want %b", c, {so, frame_start, frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({so, frame_start, frame_done} !== 3'b000) begin
                    fails++; $display("FAIL b2b c%0d idle got %b want 000", c, {so, frame_start, frame_done});
                end
            end
            n_start += int'(frame_start);
            n_done  += int'(frame_done);
            shift_en   = 1'b1;
            load_valid = (c <= 4);
            pi         = (c == 0) ? 4'b1011 : 4'b0110;
            #1;
            if (load_valid) begin
                vectors++;
                if (load_ready !== (c == 0 || c == 4)) begin
                    fails++; $display("FAIL b2b c%0d load_ready got %b want %b", c, load_ready, (c == 0 || c == 4));
                end
            end
            if (so_valid && shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
            if (load_valid && (c == 0 || c == 4)) push_word(pi, 1'b1);
        end
        load_valid = 1'b0;
        vectors++;
        if (n_start != 2 || n_done != 2) begin
            fails++; $display("FAIL b2b markers got start=%0d done=%0d want 2/2", n_start, n_done);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int n_valid = 0;
        int n_zero  = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            vectors++;
            if (so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL stall c%0d so_valid got %b want %b", c, so_valid, exp_q.size() != 0);
            end else if (so_valid) begin
                vectors++;
                if ({so, frame_start, frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL stall c%0d so/start/done got %b want %b", c, {so, frame_start, frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({so, frame_start, frame_done} !== 3'b000) begin
                    fails++; $display("FAIL stall c%0d idle got %b want 000", c, {so, frame_start, frame_done});
                end
            end
            n_valid += int'(so_valid);
            n_zero  += int'(so_valid && !so);
            shift_en   = !(c == 2 || c == 3);
            load_valid = (c == 0);
            pi         = 4'b1011;
            #1;
            if (so_valid && shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
            if (load_valid) push_word(pi, 1'b1);
        end
        load_valid = 1'b0; shift_en = 1'b1;
        vectors++;
        if (n_valid != 6 || n_zero != 3) begin
            fails++; $display("FAIL stall cycles got valid=%0d zero=%0d want 6/3", n_valid, n_zero);
        end
        exp_q.delete();
    endtask

    task automatic test_lsb_first();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++;
            if (l_so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL lsb c%0d so_valid got %b want %b", c, l_so_valid, exp_q.size() != 0);
            end else if (l_so_valid) begin
                vectors++;
                if ({l_so, l_frame_start, l_frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL lsb c%0d so/start/done got %b want %b", c, {l_so, l_frame_start, l_frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({l_so, l_frame_start, l_frame_done} !== 3'b000) begin
                    fails++; $display("FAIL lsb c%0d idle got %b want 000", c, {l_so, l_frame_start, l_frame_done});
                end
            end
            l_shift_en   = 1'b1;
            l_load_valid = (c == 0);
            l_pi         = 4'b1011;
            #1;
            if (l_so_valid && l_shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
            if (l_load_valid) push_word(l_pi, 1'b0);
        end
        l_load_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_busy_load();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL busy c%0d so_valid got %b want %b", c, so_valid, exp_q.size() != 0);
            end else if (so_valid) begin
                vectors++;
                if ({so, frame_start, frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL busy c%0d so/start/done got %b want %b", c, {so, frame_start, frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({so, frame_start, frame_done} !== 3'b000) begin
                    fails++; $display("FAIL busy c%0d idle got %b want 000", c, {so, frame_start, frame_done});
                end
            end
            shift_en   = 1'b1;
            load_valid = (c <= 1);
            pi         = (c == 0) ? 4'b1011 : 4'b0000;
            #1;
            if (c == 1) begin
                vectors++;
                if (load_ready !== 1'b0) begin
                    fails++; $display("FAIL busy c%0d load_ready got %b want 0", c, load_ready);
                end
            end
            if (so_valid && shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
            if (c == 0) push_word(pi, 1'b1);
        end
        load_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (so_valid !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL rstmid c%0d so_valid got %b want %b", c, so_valid, exp_q.size() != 0);
            end else if (so_valid) begin
                vectors++;
                if ({so, frame_start, frame_done} !== exp_q[0]) begin
                    fails++; $display("FAIL rstmid c%0d so/start/done got %b want %b", c, {so, frame_start, frame_done}, exp_q[0]);
                end
            end else begin
                vectors++;
                if ({so, frame_start, frame_done} !== 3'b000) begin
                    fails++; $display("FAIL rstmid c%0d idle got %b want 000", c, {so, frame_start, frame_done});
                end
            end
            shift_en   = 1'b1;
            rst        = (c == 2);
            load_valid = (c == 0) || (c == 3);
            pi         = (c == 0) ? 4'b1011 : 4'b0110;
            if (rst) exp_q.delete();
            #1;
            if (c == 2 || c == 3) begin
                vectors++;
                if (load_ready !== (c == 3)) begin
                    fails++; $display("FAIL rstmid c%0d load_ready got %b want %b", c, load_ready, (c == 3));
                end
            end
            if (so_valid && shift_en && !rst && exp_q.size() != 0) void'(exp_q.pop_front());
            if (load_valid) push_word(pi, 1'b1);
        end
        load_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_busy_load();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
